byte_encode_stream: RTL and testbench

Streaming ByteEncode_d packer that sits directly downstream of the Compress_d stage. It accepts one compressed coefficient per handshake, keeps only the low d bits, and concatenates them LSB-first into a bit stream. It emits that stream as bytes on a valid/ready port. One frame is one polynomial of 256 coefficients, producing exactly 32·d bytes.

---
 rtl/byte_encode_stream.sv | 162 ++++++++++++++++
 tb/tb_byte_encode_stream.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_encode_stream.sv
// byte_encode_stream
// ------------------
// Streaming ByteEncode_d packer. It takes one compressed coefficient per
// handshake and keeps its low d bits. Those bits are concatenated LSB-first
// into a bit stream, and the stream is emitted as bytes. One frame is
// N_COEFFS coefficients and always produces exactly 32*d bytes.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle frame request, honoured only in IDLE
//   d          bits per coefficient (1..12), sampled with start
//   in_valid   upstream coefficient valid
//   in_ready   coefficient accepted on in_valid && in_ready
//   in_coeff   compressed coefficient; bits above d-1 ignored
//   out_valid  out_byte holds a valid byte
//   out_ready  downstream accepts on out_valid && out_ready
//   out_byte   packed output byte
//   out_last   high with the final byte of the frame
//   busy       high while a frame is running
//   done       one-cycle pulse at frame completion
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start with a legal d
// RUN   | accepting coefficients and emitting packed bytes
// DONE  | last byte taken downstream; done pulse, back to IDLE

module byte_encode_stream #(
    parameter int N_COEFFS = 256,
    parameter int COEFF_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4:0]         d,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [9:0] N_LIMIT = 10'(N_COEFFS);

    state_t      state;
    logic [4:0]  d_q;
    logic [19:0] acc;
    logic [4:0]  bit_cnt;
    logic [8:0]  coeff_cnt;
    logic [8:0]  byte_cnt;

    logic        d_legal;
    logic        accept;
    logic        emit;
    logic        out_taken;
    logic [11:0] coeff_mask;
    logic [19:0] coeff_shifted;
    logic [9:0]  last_idx;
    logic        unused_coeff_hi;

    // Coefficient bits above bit 11 can never be part of the stream.
    assign unused_coeff_hi = ^in_coeff[COEFF_W-1:12];

    assign d_legal = (d >= 5'd1) && (d <= 5'd12);

    // in_ready comes from registers only, so upstream sees no
    // combinational path from in_valid or out_ready.
    assign in_ready = (state == S_RUN)
                    && ({1'b0, coeff_cnt} < N_LIMIT)
                    && (bit_cnt < 5'd8);

    assign accept    = in_valid && in_ready;
    assign out_taken = out_valid && out_ready;
    // Disjoint from accept: accept needs bit_cnt < 8, emit needs >= 8.
    assign emit      = (state == S_RUN) && (bit_cnt >= 5'd8)
                     && (!out_valid || out_ready);

    // The 13-bit intermediate makes d_q = 12 yield an all-ones mask.
    assign coeff_mask    = 12'((13'd1 << d_q) - 13'd1);
    // bit_cnt < 8 on accept and the value has at most 12 bits, so the
    // shifted value always fits in the 20-bit accumulator.
    assign coeff_shifted = {8'h00, in_coeff[11:0] & coeff_mask} << bit_cnt;

    // Index of the final byte of the frame: 32*d_q - 1.
    assign last_idx = {d_q, 5'b00000} - 10'd1;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            d_q       <= 5'd0;
            acc       <= 20'd0;
            bit_cnt   <= 5'd0;
            coeff_cnt <= 9'd0;
            byte_cnt  <= 9'd0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && d_legal) begin
                        d_q       <= d;
                        acc       <= 20'd0;
                        bit_cnt   <= 5'd0;
                        coeff_cnt <= 9'd0;
                        byte_cnt  <= 9'd0;
                        state     <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (accept) begin
                        acc       <= acc | coeff_shifted;
                        bit_cnt   <= bit_cnt + d_q;
                        coeff_cnt <= coeff_cnt + 9'd1;
                    end

                    if (emit) begin
                        out_byte  <= acc[7:0];
                        out_valid <= 1'b1;
                        out_last  <= ({1'b0, byte_cnt} == last_idx);
                        acc       <= acc >> 8;
                        bit_cnt   <= bit_cnt - 5'd8;
                        byte_cnt  <= byte_cnt + 9'd1;
                    end else if (out_taken) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end

                    // When the last byte is taken, bit_cnt has already
                    // drained to zero, so no emit can coincide with it.
                    if (out_taken && out_last) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_encode_stream.sv
module tb_byte_encode_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  d;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_coeff;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        busy;
    logic        done;

    byte_encode_stream #(.N_COEFFS(256), .COEFF_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeff  (in_coeff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];      // {last, byte}
    logic [15:0] cf[256];
    int         rx_cnt = 0;
    int         done_cnt = 0;
    bit         rdy_rand = 1'b0;
    int         stall_cnt = 0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_word = 9'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: lay every coefficient's low d bits into one flat bit
    // stream, then cut it into bytes (bit b -> byte b/8, position b%8).
    task automatic push_expected(input int dd);
        bit stream[3072];
        int nbytes;
        logic [7:0] b;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < dd; j++)
                stream[i*dd + j] = cf[i][j];
        nbytes = 32 * dd;
        for (int k = 0; k < nbytes; k++) begin
            for (int j = 0; j < 8; j++) b[j] = stream[8*k + j];
            exp_q.push_back({(k == nbytes - 1) ? 1'b1 : 1'b0, b});
        end
    endtask

    // Output side: random or steady out_ready, with an optional forced stall.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else begin
                out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (prev_stall) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_byte_last", 32'({out_last, out_byte}), 32'(prev_word));
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_last, out_byte};
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_byte: got 0x%0h with no byte expected", {out_last, out_byte});
                    end else begin
                        check($sformatf("byte%0d", rx_cnt), 32'({out_last, out_byte}), 32'(exp_q.pop_front()));
                    end
                    rx_cnt++;
                end
            end
        end
    end

    task automatic pulse_start(input int dd);
        start = 1'b1;
        d     = 5'(dd);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n_feed, input int gap_max, input int inj_idx);
        bit rdy;
        int t;
        for (int i = 0; i < n_feed; i++) begin
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_coeff = cf[i];
            if (i == inj_idx) begin
                start = 1'b1;
                d     = 5'd3;
            end
            t = 0;
            forever begin
                @(negedge clk);
                rdy = in_ready;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (rdy) break;
                t++;
                if (t > 2000) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL accept_timeout: coefficient %0d not accepted", i);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic stall_probe(input int stall_after);
        int t = 0;
        if (stall_after < 0) return;
        while (rx_cnt < stall_after && t < 5000) begin
            @(negedge clk);
            t++;
        end
        stall_cnt = 5;
        repeat (5) @(negedge clk);
        check("stall_in_ready_low", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic run_frame(input int dd, input bit rr, input int gap_max,
                             input int inj_idx, input int stall_after);
        int t = 0;
        rdy_rand = rr;
        rx_cnt   = 0;
        done_cnt = 0;
        push_expected(dd);
        pulse_start(dd);
        check($sformatf("busy_after_start_d%0d", dd), 32'(busy), 32'd1);
        check($sformatf("in_ready_after_start_d%0d", dd), 32'(in_ready), 32'd1);
        fork
            feed(256, gap_max, inj_idx);
            stall_probe(stall_after);
        join
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout_d%0d: %0d bytes still expected", dd, exp_q.size());
        end
        repeat (3) @(negedge clk);
        check($sformatf("byte_count_d%0d", dd), 32'(rx_cnt), 32'(32 * dd));
        check($sformatf("done_pulses_d%0d", dd), 32'(done_cnt), 32'd1);
        check($sformatf("busy_idle_d%0d", dd), 32'(busy), 32'd0);
        exp_q.delete();
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_byte"}, 32'(out_byte), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        d        = 5'd0;
        in_valid = 1'b0;
        in_coeff = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // d=4: 0x1, 0x2, then zeros -> first byte 0x21
        for (int i = 0; i < 256; i++) cf[i] = 16'h0000;
        cf[0] = 16'h0001;
        cf[1] = 16'h0002;
        run_frame(4, 1'b0, 0, -1, -1);

        // d=12: 0xABC, 0x123 lead, random rest with junk upper bits
        for (int i = 0; i < 256; i++) cf[i] = 16'($urandom);
        cf[0] = 16'h0ABC;
        cf[1] = 16'h0123;
        run_frame(12, 1'b1, 2, -1, -1);

        // d=4 with upper bits set: every byte 0x33
        for (int i = 0; i < 256; i++) cf[i] = 16'hFFF3;
        run_frame(4, 1'b1, 1, -1, -1);

        // d=1 alternating 1,0: 32 bytes of 0x55
        for (int i = 0; i < 256; i++) cf[i] = (i % 2 == 0) ? 16'h0001 : 16'h0000;
        run_frame(1, 1'b0, 0, -1, -1);

        // d=10 with a 5-cycle downstream stall after byte 20
        for (int i = 0; i < 256; i++) cf[i] = 16'($urandom);
        run_frame(10, 1'b0, 0, -1, 20);

        // d=8 random handshakes, with a stray start mid-frame
        for (int i = 0; i < 256; i++) cf[i] = 16'($urandom);
        run_frame(8, 1'b1, 3, 50, -1);

        // Illegal d values leave the block idle
        pulse_start(0);
        check("d0_busy", 32'(busy), 32'd0);
        check("d0_in_ready", 32'(in_ready), 32'd0);
        pulse_start(13);
        check("d13_busy", 32'(busy), 32'd0);
        check("d13_in_ready", 32'(in_ready), 32'd0);

        // d=7 frame abandoned by reset after 100 coefficients
        for (int i = 0; i < 256; i++) cf[i] = 16'($urandom);
        rdy_rand = 1'b1;
        rx_cnt   = 0;
        push_expected(7);
        pulse_start(7);
        feed(100, 1, -1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        exp_q.delete();
        rst      = 1'b0;
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;

        // d=5 frame after the reset
        for (int i = 0; i < 256; i++) cf[i] = 16'($urandom);
        run_frame(5, 1'b1, 1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
